// File: rtl/fma_pkg.sv
// Shared constants and fixed-point helpers for the fma multiply-accumulate cell.
package fma_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 16;
  localparam int unsigned DEFAULT_FIXED_POINT = 10;
  localparam int unsigned MAX_PROD_W          = 64;

  // Drop the fractional bits of a raw product (truncation toward zero for unsigned).
  function automatic logic [MAX_PROD_W-1:0] fx_truncate(input logic [MAX_PROD_W-1:0] prod,
                                                        input int unsigned           frac_bits);
    return prod >> frac_bits;
  endfunction

endpackage

// File: rtl/fma_fx_mul.sv
// Combinational unsigned fixed-point multiply: full product plus WIDTH-bit rescaled product.
module fma_fx_mul
  import fma_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned FIXED_POINT = DEFAULT_FIXED_POINT
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   prod_fx
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  always_comb begin
    prod    = PROD_W'(a) * PROD_W'(b);
    prod_fx = WIDTH'(fx_truncate(MAX_PROD_W'(prod), FIXED_POINT));
  end

endmodule

// File: rtl/fma.sv
// Unsigned fixed-point fused multiply-accumulate: out = a*b + c with the result fed back into c.
module fma
  import fma_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned FIXED_POINT = DEFAULT_FIXED_POINT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic               a_valid_in,
  input  logic               b_valid_in,
  input  logic               c_valid_in,
  input  logic               compute,
  output logic [WIDTH-1:0]   out,
  output logic [2*WIDTH-1:0] multiplication_full_precision
);

  logic [WIDTH-1:0]   a_reg, b_reg, c_reg;
  logic [WIDTH-1:0]   a_eff, b_eff, c_eff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_fx;
  logic [WIDTH-1:0]   sum;

  // Same-cycle bypass of freshly presented operands.
  always_comb begin
    a_eff = a_valid_in ? a : a_reg;
    b_eff = b_valid_in ? b : b_reg;
    c_eff = c_valid_in ? c : c_reg;
    sum   = prod_fx + c_eff;
  end

  fma_fx_mul #(
    .WIDTH       (WIDTH),
    .FIXED_POINT (FIXED_POINT)
  ) u_mul (
    .a       (a_eff),
    .b       (b_eff),
    .prod    (prod),
    .prod_fx (prod_fx)
  );

  // Sum wraps modulo 2^WIDTH and becomes the next accumulator value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_reg                         <= '0;
      b_reg                         <= '0;
      c_reg                         <= '0;
      out                           <= '0;
      multiplication_full_precision <= '0;
    end else begin
      a_reg <= a_eff;
      b_reg <= b_eff;
      if (compute) begin
        c_reg                         <= sum;
        out                           <= sum;
        multiplication_full_precision <= prod;
      end else begin
        c_reg <= c_eff;
      end
    end
  end

endmodule

// File: tb/tb_fma.sv
// Self-checking bench for fma: directed plan cases plus randomized traffic against a value-level model.
module tb_fma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0, c = '0;
  logic        av = 1'b0, bv = 1'b0, cv = 1'b0, comp = 1'b0;
  logic [15:0] out;
  logic [31:0] prod;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state as plain numbers.
  longint unsigned m_a, m_b, m_c, m_out, m_prod;

  always #5 clk = ~clk;

  fma #(.WIDTH(16), .FIXED_POINT(10)) dut (
    .clk_in                        (clk),
    .rst_in                        (rst),
    .a                             (a),
    .b                             (b),
    .c                             (c),
    .a_valid_in                    (av),
    .b_valid_in                    (bv),
    .c_valid_in                    (cv),
    .compute                       (comp),
    .out                           (out),
    .multiplication_full_precision (prod)
  );

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_prod = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic apply(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic,
                       input logic iav, input logic ibv, input logic icv, input logic icomp);
    longint unsigned ea, eb, ec, p, s;
    @(negedge clk);
    a = ia; b = ib; c = ic; av = iav; bv = ibv; cv = icv; comp = icomp;
    ea = iav ? longint'(ia) : m_a;
    eb = ibv ? longint'(ib) : m_b;
    ec = icv ? longint'(ic) : m_c;
    if (icomp) begin
      p      = ea * eb;
      s      = ((p / 1024) + ec) % 65536;
      m_out  = s;
      m_prod = p;
      m_c    = s;
    end else begin
      m_c = ec;
    end
    m_a = ea;
    m_b = eb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (out !== 16'h0 || prod !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: out=%h prod=%h, required 0000/00000000", out, prod);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [15:0] held;
    apply(16'h0800, 16'h0600, 16'h0000, 1, 1, 0, 1);
    vectors++;
    if (out !== 16'h0C00 || prod !== 32'h0030_0000) begin
      miscompares++;
      $display("FAIL first_mac: out=%h prod=%h, required 0c00/00300000", out, prod);
    end
    apply(16'h1480, 16'h1800, 16'h0000, 1, 1, 0, 1);
    vectors++;
    if (out !== 16'h8700) begin
      miscompares++;
      $display("FAIL accumulate: out=%h, required 8700", out);
    end
    held = out;
    for (int i = 0; i < 3; i++) begin
      apply(16'h1234, 16'h4321, 16'h0000, 0, 0, 0, 0);
      vectors++;
      if (out !== 16'h8700 || prod !== 32'h01EC_0000) begin
        miscompares++;
        $display("FAIL hold_%0d: out=%h prod=%h, required 8700/01ec0000", i, out, prod);
      end
    end
    apply(16'h1480, 16'h1800, 16'h0000, 1, 1, 1, 1);
    vectors++;
    if (out !== 16'h7B00) begin
      miscompares++;
      $display("FAIL c_restart: out=%h, required 7b00", out);
    end
    apply(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1);
    vectors++;
    if (out !== 16'hF600) begin
      miscompares++;
      $display("FAIL reuse_regs: out=%h, required f600", out);
    end
    apply(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1);
    vectors++;
    if (out !== 16'h7100) begin
      miscompares++;
      $display("FAIL wrap: out=%h, required 7100", out);
    end
  endtask

  task automatic test_truncation();
    apply(16'h0001, 16'h0001, 16'h0000, 1, 1, 1, 1);
    vectors++;
    if (out !== 16'h0000 || prod !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL truncation: out=%h prod=%h, required 0000/00000001", out, prod);
    end
    apply(16'hFFFF, 16'hFFFF, 16'h0003, 1, 1, 1, 1);
    vectors++;
    if (out !== 16'hFF83 || prod !== 32'hFFFE_0001) begin
      miscompares++;
      $display("FAIL max_operands: out=%h prod=%h, required ff83/fffe0001", out, prod);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      vectors++;
      if (out !== 16'(m_out) || prod !== 32'(m_prod)) begin
        miscompares++;
        $display("FAIL random_%0d: out=%h prod=%h, required %h/%h",
                 i, out, prod, 16'(m_out), 32'(m_prod));
      end
    end
  endtask

  task automatic test_async_reset();
    apply(16'h0C00, 16'h0A00, 16'h0100, 1, 1, 1, 1);
    @(negedge clk);
    comp = 1'b0; av = 1'b0; bv = 1'b0; cv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (out !== 16'h0 || prod !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: out=%h prod=%h, required 0000/00000000", out, prod);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1);
    vectors++;
    if (out !== 16'h0 || prod !== 32'h0) begin
      miscompares++;
      $display("FAIL regs_cleared: out=%h prod=%h, required 0000/00000000", out, prod);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_truncation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fma.md
Name: fma

Overview:
- Unsigned fixed-point fused multiply-accumulate cell: out = a*b + c, registered.
- Internal operand registers for a, b and c; each result is written back into the c register, so back-to-back computes form a running dot product.
- Building block for the GPU compute lanes; one result per cycle, one-cycle latency.

Parameters:
- WIDTH, 16, total operand/result width in bits.
- FIXED_POINT, 10, number of fractional bits (default format is unsigned Q6.10).

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- a  input  WIDTH  multiplicand, unsigned fixed point.
- b  input  WIDTH  multiplier, unsigned fixed point.
- c  input  WIDTH  addend / accumulator load value, unsigned fixed point.
- a_valid_in  input  1  a is valid this cycle; load it into a_reg.
- b_valid_in  input  1  b is valid this cycle; load it into b_reg.
- c_valid_in  input  1  c is valid this cycle; load it into c_reg (overrides accumulation).
- compute  input  1  perform one FMA this cycle.
- out  output  WIDTH  registered result, fixed point.
- multiplication_full_precision  output  2*WIDTH  registered raw product a*b (2*FIXED_POINT fractional bits).

Behaviour:
- Reset is asynchronous and active-high. While rst_in=1: a_reg, b_reg, c_reg, out and multiplication_full_precision are all 0.
- Effective operands in a cycle:
  - a_eff = a_valid_in ? a : a_reg; same rule for b_eff and c_eff.
  - The valid bypass applies in the same cycle, so no extra latency is added.
- Datapath arithmetic, all unsigned:
  - prod = a_eff * b_eff, width 2*WIDTH.
  - prod_fx = prod >> FIXED_POINT, truncated toward zero, keeping the low WIDTH bits.
  - sum = prod_fx + c_eff, modulo 2^WIDTH (wraps; no saturation).
- Rising edge with compute=1:
  - out <= sum.
  - multiplication_full_precision <= prod.
  - c_reg <= sum (accumulate).
  - a_reg <= a_eff; b_reg <= b_eff.
- Rising edge with compute=0:
  - out and multiplication_full_precision hold.
  - Each x_reg loads its input if x_valid_in=1, otherwise holds.
- Latency is 1 cycle: the result of a compute in cycle N is visible on out after edge N.
- compute with no valid inputs reuses the stored a_reg and b_reg, and adds the previous result.
- c_valid_in together with compute: the c input replaces the accumulator for that operation (restart of a dot product).
- Reset asserted mid-accumulation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Package fma_pkg holds:
  - localparams DEFAULT_WIDTH=16 and DEFAULT_FIXED_POINT=10;
  - a helper function for the fixed-point shift/truncate.
- One natural sub-module, fma_fx_mul: combinational unsigned multiply that outputs both the full product and the shifted WIDTH-bit product.
- Operand registers, accumulator and output registers stay in the fma top.

Test Plan:
- Reset: pulse rst_in with no clock edge pending -> out=0, multiplication_full_precision=0 immediately.
- After reset, a=0x0800 (2), b=0x0600 (1.5), a/b valid, compute=1 for one cycle -> out=0x0C00 (3), full product=0x00300000.
- Next a=0x1480 (5.125), b=0x1800 (6), a/b valid, c_valid_in=0, compute=1 -> out=0x8700 (33.75, accumulated); out then holds while compute=0.
- Same a/b with c=0x0000 and c_valid_in=1, compute=1 -> out=0x7B00 (30.75).
- compute=1 with no valid inputs after the previous case -> out=0xF600 (30.75+30.75=61.5); a further compute wraps modulo 2^16 -> out=0x7100.
- Fractional truncation: a=0x0001, b=0x0001, c_valid_in=1 with c=0 -> out=0x0000, full product=0x00000001.
